pos_decoder_3to8: RTL and testbench

POS_DECODER_3TO8 -- requirements
Module: pos_decoder_3to8

---
 rtl/pos_decoder_3to8_pkg.sv | 33 +++
 rtl/pos_decoder_3to8_onehot.sv | 24 ++
 rtl/pos_decoder_3to8.sv | 111 +++++++++++
 tb/tb_pos_decoder_3to8.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pos_decoder_3to8_pkg.sv
// ---------------------------------------------------------------------------
// pos_decoder_3to8_pkg
// Shared constants and types for the position-to-bitmask decoder.
//   WORD_W  : width of the reconstructed bitmask word
//   POS_W   : width of a bit-position beat (0 = MSB)
//   CNT_W   : width of the set-bit count (must hold 0..WORD_W)
//   state_t : two-state control type (accumulating / output stage full)
//   popcount: number of set bits in a word
// ---------------------------------------------------------------------------
package pos_decoder_3to8_pkg;

  localparam int WORD_W = 8;
  localparam int POS_W  = 3;
  localparam int CNT_W  = 4;

  // ST_ACCUM: a word is being gathered (or nothing is in flight).
  // ST_FULL : the output stage holds a finished word awaiting handshake.
  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Counts the ones in a word; the count width covers the all-ones case.
  function automatic logic [CNT_W-1:0] popcount(input logic [WORD_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pos_decoder_3to8_onehot.sv
// ---------------------------------------------------------------------------
// onehot_decoder_3to8
// Combinational MSB-first position decoder.
//   i_pos    : bit position, 0 selects bit 7, 7 selects bit 0
//   i_en     : when low the output is all zeros
//   o_onehot : one-hot word with bit (7 - i_pos) set when enabled
// ---------------------------------------------------------------------------
module onehot_decoder_3to8
  import pos_decoder_3to8_pkg::*;
(
  input  logic [POS_W-1:0]  i_pos,
  input  logic              i_en,
  output logic [WORD_W-1:0] o_onehot
);

  // Positions count from the MSB, so the target index is mirrored.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[POS_W'(WORD_W - 1) - i_pos] = 1'b1;
    end
  end

endmodule

// File: rtl/pos_decoder_3to8.sv
// ---------------------------------------------------------------------------
// pos_decoder_3to8
// Rebuilds an 8-bit bitmask from a stream of MSB-first bit-position beats.
// Positions within a word must strictly ascend; violations (or a zero-word
// marker arriving after positions) flag the word with out_err.
//   clk, reset   : rising-edge clock, asynchronous active-high reset
//   in_valid     : position beat present
//   in_ready     : beat accepted when in_valid && in_ready
//   in_pos       : bit position, 0 = bit 7 ... 7 = bit 0
//   in_zero      : beat marks an all-zero word (implies last, pos ignored)
//   in_last      : final position beat of the word
//   out_valid    : reconstructed word available
//   out_ready    : downstream accepts word when out_valid && out_ready
//   out_bitmask  : reconstructed word
//   out_count    : number of set bits in out_bitmask
//   out_err      : word broke ordering / zero rules
// ---------------------------------------------------------------------------
module pos_decoder_3to8
  import pos_decoder_3to8_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POS_W-1:0]  in_pos,
  input  logic              in_zero,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_bitmask,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err
);

  state_t              r_state;
  logic [WORD_W-1:0]   r_acc;
  logic                r_err;
  logic [POS_W-1:0]    r_lastPos;
  logic                r_first;
  logic [WORD_W-1:0]   r_outBitmask;
  logic [CNT_W-1:0]    r_outCount;
  logic                r_outErr;

  logic [WORD_W-1:0]   w_decoded;
  logic                w_accept;
  logic                w_complete;
  logic                w_orderErr;
  logic                w_zeroErr;
  logic [WORD_W-1:0]   w_word;
  logic                w_wordErr;

  // A zero-word beat carries no position, so the decoder is gated off.
  onehot_decoder_3to8 u_decoder (
    .i_pos    (in_pos),
    .i_en     (!in_zero),
    .o_onehot (w_decoded)
  );

  assign out_valid   = (r_state == ST_FULL);
  assign in_ready    = !out_valid || out_ready;
  assign out_bitmask = r_outBitmask;
  assign out_count   = r_outCount;
  assign out_err     = r_outErr;

  assign w_accept   = in_valid && in_ready;
  assign w_complete = w_accept && (in_last || in_zero);

  // The first beat of a word has no predecessor to compare against.
  assign w_orderErr = !in_zero && !r_first && (in_pos <= r_lastPos);
  assign w_zeroErr  = in_zero && (r_acc != '0);
  assign w_word     = in_zero ? r_acc : (r_acc | w_decoded);
  assign w_wordErr  = r_err || w_orderErr || w_zeroErr;

  // A completing beat moves the word to the output stage and resets the
  // accumulator in the same edge; a simultaneous output handshake is
  // covered because in_ready was already high, so the stage just reloads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_ACCUM;
      r_acc        <= '0;
      r_err        <= 1'b0;
      r_lastPos    <= '0;
      r_first      <= 1'b1;
      r_outBitmask <= '0;
      r_outCount   <= '0;
      r_outErr     <= 1'b0;
    end else begin
      if (w_complete) begin
        r_outBitmask <= w_word;
        r_outCount   <= popcount(w_word);
        r_outErr     <= w_wordErr;
        r_state      <= ST_FULL;
        r_acc        <= '0;
        r_err        <= 1'b0;
        r_lastPos    <= '0;
        r_first      <= 1'b1;
      end else begin
        if (w_accept) begin
          r_acc     <= w_word;
          r_err     <= w_wordErr;
          r_lastPos <= in_pos;
          r_first   <= 1'b0;
        end
        if (out_valid && out_ready) begin
          r_state <= ST_ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_pos_decoder_3to8.sv
// ---------------------------------------------------------------------------
// tb_pos_decoder_3to8
// Directed bench for pos_decoder_3to8. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the rising
// edge that updates the design.
// ---------------------------------------------------------------------------
module tb_pos_decoder_3to8;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_pos;
  logic       in_zero;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_bitmask;
  logic [3:0] out_count;
  logic       out_err;

  int numChecks = 0;
  int numFails  = 0;

  pos_decoder_3to8 dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pos      (in_pos),
    .in_zero     (in_zero),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bitmask (out_bitmask),
    .out_count   (out_count),
    .out_err     (out_err)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one beat (or idle when valid is low) and lets one rising edge
  // pass, returning on the following falling edge.
  task automatic applyStimulus(input logic valid, input logic [2:0] pos,
                               input logic last, input logic zero);
    in_valid = valid;
    in_pos   = pos;
    in_last  = last;
    in_zero  = zero;
    @(negedge clk);
  endtask

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    numChecks++;
    assert (observed === expected)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Checks the whole output stage in one call.
  task automatic checkWord(input string tag, input logic valid,
                           input logic [7:0] mask, input logic [3:0] cnt,
                           input logic err);
    checkOutput({tag, ".valid"}, {7'd0, out_valid}, {7'd0, valid});
    checkOutput({tag, ".mask"}, out_bitmask, mask);
    checkOutput({tag, ".count"}, {4'd0, out_count}, {4'd0, cnt});
    checkOutput({tag, ".err"}, {7'd0, out_err}, {7'd0, err});
  endtask

  // Directed sequence: each block below targets one behaviour.
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pos    = '0;
    in_zero   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkWord("reset", 1'b0, 8'h00, 4'd0, 1'b0);
    checkOutput("reset.in_ready", {7'd0, in_ready}, 8'h01);

    $display("[TB] positions 0,3,7");
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
    checkOutput("w1.mid_valid", {7'd0, out_valid}, 8'h00);
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd7, 1'b1, 1'b0);
    checkWord("w1", 1'b1, 8'b1001_0001, 4'd3, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("w1.drain", {7'd0, out_valid}, 8'h00);

    $display("[TB] zero words back to back");
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b1);
    checkWord("zero1", 1'b1, 8'h00, 4'd0, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b1);
    checkOutput("zero2.valid", {7'd0, out_valid}, 8'h01);
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b1);
    checkOutput("zero3.valid", {7'd0, out_valid}, 8'h01);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("zero.drain", {7'd0, out_valid}, 8'h00);

    $display("[TB] descending order error then clean word");
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
    checkWord("order", 1'b1, 8'b0010_1000, 4'd2, 1'b1);
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0);
    checkWord("clean", 1'b1, 8'b0100_0000, 4'd1, 1'b0);

    $display("[TB] repeated position error");
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
    checkWord("repeat", 1'b1, 8'b0001_0000, 4'd1, 1'b1);

    $display("[TB] zero marker after positions");
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd6, 1'b0, 1'b1);
    checkWord("zeroErr", 1'b1, 8'b0010_0000, 4'd1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

    $display("[TB] output stall");
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
    checkWord("stall.held", 1'b1, 8'b0000_0010, 4'd1, 1'b0);
    in_pos  = 3'd0;
    in_last = 1'b1;
    #1;
    checkOutput("stall.in_ready", {7'd0, in_ready}, 8'h00);
    @(negedge clk);
    checkWord("stall.stable", 1'b1, 8'b0000_0010, 4'd1, 1'b0);
    out_ready = 1'b1;
    #1;
    checkOutput("release.in_ready", {7'd0, in_ready}, 8'h01);
    @(negedge clk);
    checkWord("release", 1'b1, 8'b1000_0000, 4'd1, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("release.drain", {7'd0, out_valid}, 8'h00);

    $display("[TB] all positions");
    for (int p = 0; p < 8; p++) begin
      applyStimulus(1'b1, 3'(p), (p == 7), 1'b0);
    end
    checkWord("full", 1'b1, 8'hFF, 4'd8, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midReset.valid", {7'd0, out_valid}, 8'h00);
    applyStimulus(1'b1, 3'd5, 1'b1, 1'b0);
    checkWord("afterReset", 1'b1, 8'b0000_0100, 4'd1, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
